// File: rtl/ram_burst_pkg.sv
// Shared types and constants for the RAM burst reader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/ram_burst_addr_gen.sv
// Read pointer and remaining-word counter with modulo-depth wrap.
// Latency: pointer/count update on the edge after load_i or adv_i.
// Backpressure: holds pointer and count whenever adv_i is low.
module ram_burst_addr_gen #(
  parameter int depth_p = 128,
  parameter int aw_p    = 7
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            load_i,
  input  logic [aw_p-1:0] base_i,
  input  logic [aw_p:0]   len_i,
  input  logic            adv_i,
  output logic [aw_p-1:0] ptr_o,
  output logic            empty_o
);

  logic [aw_p-1:0] ptr_q, ptr_d;
  logic [aw_p:0]   rem_q, rem_d;

  // Next pointer/count: load wins, otherwise advance with wrap at depth_p-1.
  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    if (load_i) begin
      ptr_d = base_i;
      rem_d = len_i;
    end else if (adv_i) begin
      ptr_d = (ptr_q == aw_p'(depth_p - 1)) ? '0 : ptr_q + aw_p'(1);
      rem_d = rem_q - (aw_p+1)'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q <= '0;
      rem_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rem_q <= rem_d;
    end
  end

  assign ptr_o   = ptr_q;
  assign empty_o = (rem_q == '0);

endmodule

// File: rtl/ram_burst_reader.sv
// Streams a burst of consecutive RAM words out as a valid/ready stream.
// Latency: first word valid one cycle after start is accepted; then 1 word/cycle.
// Backpressure: data, pointer and count hold while valid_o && !ready_i.
// Optional: define RAM_BURST_READER_STALL_CNT_EN to add the stall_cnt_o counter.
module ram_burst_reader
  import ram_burst_pkg::*;
#(
  parameter int  width_p = 8,
  parameter int  depth_p = 128,
  localparam int AW      = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [AW-1:0]      base_addr_i,
  input  logic [AW:0]        len_i,
  output logic [AW-1:0]      rd_addr_o,
  input  logic [width_p-1:0] rd_data_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i,
  output logic               busy_o,
  output logic               done_o
`ifdef RAM_BURST_READER_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(depth_p);

  state_e             state_q;
  logic               valid_q;
  logic [width_p-1:0] data_q;
  logic               busy_q;
  logic               done_q;

  logic               accept;
  logic [AW:0]        len_clamped;
  logic               empty;
  logic               slot_free;
  logic               load;
  logic               finish;

  // Lengths beyond the RAM depth are clamped so a burst never rereads a word.
  assign len_clamped = (len_i > DEPTH_L) ? DEPTH_L : len_i;
  assign accept      = (state_q == IDLE) && start_i;
  assign slot_free   = !valid_q || ready_i;
  assign load        = (state_q == RUN) && !empty && slot_free;
  assign finish      = (state_q == RUN) && empty && slot_free;

  ram_burst_addr_gen #(
    .depth_p (depth_p),
    .aw_p    (AW)
  ) u_addr_gen (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (accept),
    .base_i  (base_addr_i),
    .len_i   (len_clamped),
    .adv_i   (load),
    .ptr_o   (rd_addr_o),
    .empty_o (empty)
  );

  // Burst FSM with the output slot register and registered status outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (len_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (load) begin
            data_q  <= rd_data_i;
            valid_q <= 1'b1;
          end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
          end
          if (finish) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

`ifdef RAM_BURST_READER_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of RUN cycles where a word waits on downstream.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (accept) begin
      stall_cnt_d = '0;
    end else if ((state_q == RUN) && valid_q && !ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Downstream consumer of the write-first asynchronous RAM.
- Generates read addresses for a burst of consecutive words, captures the combinational read data into an output register, and presents the words as a valid/ready stream to the systolic-array feeder.
- One burst per start command; done pulse on completion.

Parameters:
- width_p, 8: data word width; must match the RAM's width.
- depth_p, 128: RAM depth; address width AW = $clog2(depth_p); need not be a power of two.

Ports:
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  burst request; sampled only in IDLE.
- base_addr_i  in  AW  first read address, latched on accepted start.
- len_i  in  AW+1  number of words in the burst, 0..depth_p; latched on accepted start.
- rd_addr_o  out  AW  address to the RAM read port.
- rd_data_i  in  width_p  combinational read data returned by the RAM.
- valid_o  out  1  data_o holds a valid word.
- data_o  out  width_p  stream data.
- ready_i  in  1  downstream accepts data_o when high together with valid_o.
- busy_o  out  1  high in RUN and DONE.
- done_o  out  1  one-cycle pulse when the burst completes.

Behaviour:
- Reset (asynchronous) forces the following values immediately:
  - state = IDLE
  - valid_o = 0, data_o = 0, done_o = 0, busy_o = 0
  - rd_addr_o = 0, remaining count = 0
- Reset mid-burst abandons the burst; no done_o pulse is issued.
- FSM states and transitions:
  - IDLE:
    - If start_i = 1, latch base_addr_i into the pointer and len_i into the remaining count.
    - Go to DONE if len_i = 0; otherwise go to RUN.
  - RUN:
    - rd_addr_o = pointer (registered).
    - Load condition = (remaining != 0) and (!valid_o or ready_i).
    - On load:
      - data_o <= rd_data_i, valid_o <= 1
      - pointer advances, wrapping from depth_p-1 to 0
      - remaining decrements
    - If valid_o and ready_i and no load occurs, valid_o <= 0.
    - When remaining = 0 and the slot is empty, or the final word handshakes this cycle: go to DONE.
  - DONE:
    - done_o = 1 for exactly one cycle.
    - Go to IDLE.
- start_i is ignored outside IDLE.
- Latency and throughput:
  - Start is accepted at edge E0; valid_o rises after E1 (one cycle in RUN).
  - With ready_i held high, one word per cycle.
  - done_o is high in the cycle after the last handshake.
- Handshake rules:
  - data_o is held stable while valid_o = 1 and ready_i = 0.
  - valid_o never drops without a handshake, except on reset.
  - The stream carries exactly len words, in address order.
- Stall: while the slot is full and ready_i = 0, the pointer and the count hold. rd_addr_o stays stable, so the RAM's write-first bypass of a concurrent write to that address is captured when the load finally happens.
- Wrap: base = depth_p-2 with len = 4 reads depth_p-2, depth_p-1, 0, 1.
- len = depth_p reads the whole RAM once.
- len > depth_p is illegal; the implementation must clamp it to depth_p.

Optional Feature:
- Macro: RAM_BURST_READER_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o (16 bits). It counts cycles in RUN with valid_o = 1 and ready_i = 0.
  - The counter saturates at 16'hFFFF, clears on an accepted start, and resets to 0.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ram_burst_pkg holds:
  - state enum type state_e {IDLE, RUN, DONE}
  - the stall counter width constant (16)
- One natural sub-module, ram_burst_addr_gen: pointer plus remaining counter with modulo-depth wrap, load and advance inputs, and an empty output.
- The output register and FSM stay in the top level.

Test Plan:
- RAM preloaded with mem[i] = i; start with base = 5, len = 4, ready_i = 1.
  - valid_o rises one cycle after start.
  - data_o = 5, 6, 7, 8 on consecutive cycles.
  - done_o pulses once, the cycle after data 8; busy_o then falls.
- Backpressure: same burst with ready_i low for 3 cycles while data_o = 6.
  - data_o holds 6 and rd_addr_o holds 7 throughout.
  - No word is lost or duplicated.
- Wrap: depth_p = 128, base = 126, len = 4.
  - Stream is 126, 127, 0, 1.
  - rd_addr_o sequence is 126, 127, 0, 1.
- len = 0 start: no valid_o; busy_o is high for one cycle and done_o pulses; the FSM returns to IDLE.
- Reset asserted after the 2nd word of an 8-word burst.
  - valid_o and busy_o drop without waiting for a clock edge; done_o never pulses.
  - A new start with base = 0, len = 2 then streams 0, 1 normally.
- start_i held high throughout a burst: only one burst runs.
  - A second burst starts only when start_i is seen in IDLE after done_o.
  - With RAM_BURST_READER_STALL_CNT_EN defined, 3 stall cycles give stall_cnt_o = 3.
